// File: rtl/pong_engine.sv
// pong_engine: two-player paddle-and-ball game engine for the LED-matrix board.
// It owns the paddle positions, the ball position and direction, wall and
// paddle reflection, scoring, and the serve / point / game-over sequence.
//
// Ports:
//   CLK          system clock
//   RST          asynchronous active-high reset
//   PUSH[3:0]    buttons: [1] P1 left, [0] P1 right, [3] P2 left, [2] P2 right
//   SERVE        serve / restart request (level; acts on its rising edge)
//   PAD1_X       leftmost column of paddle 1 (bottom)
//   PAD2_X       leftmost column of paddle 2 (top)
//   BALL_X/Y     ball column / row (row 0 is the top)
//   SCORE1/2     player scores
//   STATE        0 IDLE, 1 PLAY, 2 POINT, 3 OVER
//   POINT_PULSE  one-cycle strobe when a point is awarded
//
// Optional feature macro: PONG_SPEEDUP_EN. When defined, every paddle hit
// shortens the ball period by BALL_DIV/8, down to BALL_DIV/2. The period goes
// back to BALL_DIV when a point is scored.
module pong_engine #(
  parameter int FIELD_W   = 16,
  parameter int FIELD_H   = 32,
  parameter int PAD_LEN   = 3,
  parameter int PAD1_Y    = 28,
  parameter int PAD2_Y    = 3,
  parameter int PAD_DIV   = 2000,
  parameter int BALL_DIV  = 4000000,
  parameter int WIN_SCORE = 9
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [3:0]                 PUSH,
  input  logic                       SERVE,
  output logic [$clog2(FIELD_W)-1:0] PAD1_X,
  output logic [$clog2(FIELD_W)-1:0] PAD2_X,
  output logic [$clog2(FIELD_W)-1:0] BALL_X,
  output logic [$clog2(FIELD_H)-1:0] BALL_Y,
  output logic [3:0]                 SCORE1,
  output logic [3:0]                 SCORE2,
  output logic [1:0]                 STATE,
  output logic                       POINT_PULSE
);

  localparam int XW  = $clog2(FIELD_W);
  localparam int YW  = $clog2(FIELD_H);
  localparam int PCW = (PAD_DIV > 1) ? $clog2(PAD_DIV) : 1;
  localparam int BCW = $clog2(BALL_DIV + 1);

  localparam logic [XW-1:0] PAD_MAX  = XW'(FIELD_W - PAD_LEN);
  localparam logic [XW-1:0] PAD_SPAN = XW'(PAD_LEN - 1);
  localparam logic [XW-1:0] HALF     = XW'(PAD_LEN / 2);
  localparam logic [XW-1:0] X_MAX    = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(FIELD_H - 1);
  localparam logic [YW-1:0] HIT1_Y   = YW'(PAD1_Y - 1);
  localparam logic [YW-1:0] HIT2_Y   = YW'(PAD2_Y + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  padCnt_q, padCnt_d;
  logic [BCW-1:0]  ballCnt_q, ballCnt_d;
  logic [3:0]      btnS1_q, btnS1_d, btnS2_q, btnS2_d;
  logic            srvS1_q, srvS2_q, srvPrev_q;
  logic [XW-1:0]   pad1_q, pad1_d, pad2_q, pad2_d;
  logic [XW-1:0]   ballX_q, ballX_d;
  logic [YW-1:0]   ballY_q, ballY_d;
  logic            down_q, down_d;
  logic            dxOn_q, dxOn_d, dxLeft_q, dxLeft_d;
  logic            server_q, server_d;
  logic            scorer_q, scorer_d;
  logic [3:0]      score1_q, score1_d, score2_q, score2_d;
  logic            pulse_q, pulse_d;

  logic            padTick, ballTick, serveEdge;
  logic [3:0]      btnEdge;
  logic            hit1, hit2;
  logic [XW-1:0]   hitPad;

`ifdef PONG_SPEEDUP_EN
  localparam int STEP = BALL_DIV / 8;
  localparam int MINP = BALL_DIV / 2;
  // ballPer_q is the period in force; perPend_q is picked up at the next wrap.
  logic [BCW-1:0]  ballPer_q, ballPer_d, perPend_q, perPend_d;
  assign ballTick = (ballCnt_q == ballPer_q - BCW'(1));
`else
  assign ballTick = (ballCnt_q == BCW'(BALL_DIV - 1));
`endif

  assign padTick   = (padCnt_q == PCW'(PAD_DIV - 1));
  assign btnEdge   = btnS1_q & ~btnS2_q;
  assign serveEdge = srvS2_q & ~srvPrev_q;

  // Hit tests use the registered paddle, i.e. the value before any paddle
  // move that lands on the same clock.
  assign hit1 = down_q && (ballY_q == HIT1_Y) &&
                (ballX_q >= pad1_q) && (ballX_q <= pad1_q + PAD_SPAN);
  assign hit2 = !down_q && (ballY_q == HIT2_Y) &&
                (ballX_q >= pad2_q) && (ballX_q <= pad2_q + PAD_SPAN);
  assign hitPad = hit1 ? pad1_q : pad2_q;

  // Dividers, button samplers and paddles run in every state.
  always_comb begin
    padCnt_d  = padTick ? '0 : padCnt_q + PCW'(1);
    ballCnt_d = ballTick ? '0 : ballCnt_q + BCW'(1);
    btnS1_d   = padTick ? PUSH : btnS1_q;
    btnS2_d   = padTick ? btnS1_q : btnS2_q;
    pad1_d    = pad1_q;
    pad2_d    = pad2_q;
    if (padTick) begin
      if (btnEdge[1]) begin
        if (pad1_q != '0) pad1_d = pad1_q - XW'(1);
      end else if (btnEdge[0]) begin
        if (pad1_q != PAD_MAX) pad1_d = pad1_q + XW'(1);
      end
      if (btnEdge[3]) begin
        if (pad2_q != '0) pad2_d = pad2_q - XW'(1);
      end else if (btnEdge[2]) begin
        if (pad2_q != PAD_MAX) pad2_d = pad2_q + XW'(1);
      end
    end
  end

  // Game FSM: ball motion, scoring and the serve / point / over sequence.
  always_comb begin
    state_d  = state_q;
    ballX_d  = ballX_q;
    ballY_d  = ballY_q;
    down_d   = down_q;
    dxOn_d   = dxOn_q;
    dxLeft_d = dxLeft_q;
    server_d = server_q;
    scorer_d = scorer_q;
    score1_d = score1_q;
    score2_d = score2_q;
    pulse_d  = 1'b0;
`ifdef PONG_SPEEDUP_EN
    perPend_d = perPend_q;
    ballPer_d = ballTick ? perPend_q : ballPer_q;
`endif
    case (state_q)
      IDLE: begin
        // Ball sits on the server's paddle until the serve.
        ballY_d = server_q ? HIT2_Y : HIT1_Y;
        ballX_d = (server_q ? pad2_q : pad1_q) + HALF;
        if (serveEdge) begin
          state_d = PLAY;
          dxOn_d  = 1'b0;
          down_d  = server_q;
        end
      end
      PLAY: begin
        if (ballTick) begin
          if (hit1 || hit2) begin
            down_d = !down_q;
            if (ballX_q == hitPad) begin
              dxOn_d   = 1'b1;
              dxLeft_d = 1'b1;
            end else if (ballX_q == hitPad + PAD_SPAN) begin
              dxOn_d   = 1'b1;
              dxLeft_d = 1'b0;
            end
`ifdef PONG_SPEEDUP_EN
            perPend_d = (perPend_q >= BCW'(MINP + STEP)) ?
                        perPend_q - BCW'(STEP) : BCW'(MINP);
`endif
          end else if (down_q && (ballY_q == Y_MAX)) begin
            if (score2_q != 4'd15) score2_d = score2_q + 4'd1;
            scorer_d = 1'b1;
            pulse_d  = 1'b1;
            state_d  = POINT;
`ifdef PONG_SPEEDUP_EN
            perPend_d = BCW'(BALL_DIV);
`endif
          end else if (!down_q && (ballY_q == '0)) begin
            if (score1_q != 4'd15) score1_d = score1_q + 4'd1;
            scorer_d = 1'b0;
            pulse_d  = 1'b1;
            state_d  = POINT;
`ifdef PONG_SPEEDUP_EN
            perPend_d = BCW'(BALL_DIV);
`endif
          end else begin
            ballY_d = down_q ? ballY_q + YW'(1) : ballY_q - YW'(1);
            // A ball against a side wall flips its dx before stepping.
            if (dxOn_q) begin
              if (dxLeft_q) begin
                if (ballX_q == '0) begin
                  dxLeft_d = 1'b0;
                  ballX_d  = ballX_q + XW'(1);
                end else begin
                  ballX_d  = ballX_q - XW'(1);
                end
              end else begin
                if (ballX_q == X_MAX) begin
                  dxLeft_d = 1'b1;
                  ballX_d  = ballX_q - XW'(1);
                end else begin
                  ballX_d  = ballX_q + XW'(1);
                end
              end
            end
          end
        end
      end
      POINT: begin
        if (ballTick) begin
          if ((scorer_q ? score2_q : score1_q) == 4'(WIN_SCORE)) begin
            state_d = OVER;
          end else begin
            state_d  = IDLE;
            server_d = ~scorer_q;
          end
        end
      end
      OVER: begin
        if (serveEdge) begin
          score1_d = '0;
          score2_d = '0;
          server_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register for everything above.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      padCnt_q  <= '0;
      ballCnt_q <= '0;
      btnS1_q   <= '0;
      btnS2_q   <= '0;
      srvS1_q   <= 1'b0;
      srvS2_q   <= 1'b0;
      srvPrev_q <= 1'b0;
      pad1_q    <= '0;
      pad2_q    <= PAD_MAX;
      ballX_q   <= HALF;
      ballY_q   <= HIT1_Y;
      down_q    <= 1'b0;
      dxOn_q    <= 1'b0;
      dxLeft_q  <= 1'b0;
      server_q  <= 1'b0;
      scorer_q  <= 1'b0;
      score1_q  <= '0;
      score2_q  <= '0;
      pulse_q   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      ballPer_q <= BCW'(BALL_DIV);
      perPend_q <= BCW'(BALL_DIV);
`endif
    end else begin
      state_q   <= state_d;
      padCnt_q  <= padCnt_d;
      ballCnt_q <= ballCnt_d;
      btnS1_q   <= btnS1_d;
      btnS2_q   <= btnS2_d;
      srvS1_q   <= SERVE;
      srvS2_q   <= srvS1_q;
      srvPrev_q <= srvS2_q;
      pad1_q    <= pad1_d;
      pad2_q    <= pad2_d;
      ballX_q   <= ballX_d;
      ballY_q   <= ballY_d;
      down_q    <= down_d;
      dxOn_q    <= dxOn_d;
      dxLeft_q  <= dxLeft_d;
      server_q  <= server_d;
      scorer_q  <= scorer_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      pulse_q   <= pulse_d;
`ifdef PONG_SPEEDUP_EN
      ballPer_q <= ballPer_d;
      perPend_q <= perPend_d;
`endif
    end
  end

  assign PAD1_X      = pad1_q;
  assign PAD2_X      = pad2_q;
  assign BALL_X      = ballX_q;
  assign BALL_Y      = ballY_q;
  assign SCORE1      = score1_q;
  assign SCORE2      = score2_q;
  assign STATE       = state_q;
  assign POINT_PULSE = pulse_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed self-checking bench for pong_engine on a small
// 8x8 field (PAD_LEN 3, paddles on rows 6 and 1, paddle tick every clock,
// ball tick every 4 clocks, first to 2 points wins).
module tb_pong_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] PUSH;
  logic       SERVE;
  logic [2:0] PAD1_X, PAD2_X, BALL_X, BALL_Y;
  logic [3:0] SCORE1, SCORE2;
  logic [1:0] STATE;
  logic       POINT_PULSE;

  int testsRun = 0;
  int testsFailed = 0;

  pong_engine #(
    .FIELD_W(8), .FIELD_H(8), .PAD_LEN(3), .PAD1_Y(6), .PAD2_Y(1),
    .PAD_DIV(1), .BALL_DIV(4), .WIN_SCORE(2)
  ) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .SERVE(SERVE),
    .PAD1_X(PAD1_X), .PAD2_X(PAD2_X), .BALL_X(BALL_X), .BALL_Y(BALL_Y),
    .SCORE1(SCORE1), .SCORE2(SCORE2), .STATE(STATE), .POINT_PULSE(POINT_PULSE)
  );

  always #5 CLK = ~CLK;

  // Press a button n times, one clock high and one clock low each time.
  task automatic pulseBtn(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) PUSH[b] = 1'b1;
      @(negedge CLK) PUSH[b] = 1'b0;
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic waitState(input logic [1:0] st, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (STATE === st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitBallChange(input logic [5:0] prev, output logic [5:0] now, output bit ok);
    ok = 1'b0;
    now = prev;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if ({BALL_X, BALL_Y} !== prev) begin
        now = {BALL_X, BALL_Y};
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; PUSH = 4'b0; SERVE = 1'b0;
    repeat (3) @(negedge CLK);
    testsRun++;
    if (PAD1_X !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_pad1: got %0d expected 0", PAD1_X); end
    testsRun++;
    if (PAD2_X !== 3'd5) begin testsFailed++; $display("[TB] FAIL reset_pad2: got %0d expected 5", PAD2_X); end
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd1, 3'd5}) begin testsFailed++; $display("[TB] FAIL reset_ball: got (%0d,%0d) expected (1,5)", BALL_X, BALL_Y); end
    testsRun++;
    if ({SCORE1, SCORE2} !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_scores: got %0d/%0d expected 0/0", SCORE1, SCORE2); end
    testsRun++;
    if (STATE !== 2'd0 || POINT_PULSE !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_state: got state %0d pulse %0d expected 0 0", STATE, POINT_PULSE); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_paddles;
    pulseBtn(0, 6);
    testsRun++;
    if (PAD1_X !== 3'd5) begin testsFailed++; $display("[TB] FAIL pad1_right_clamp: got %0d expected 5", PAD1_X); end
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd6, 3'd5}) begin testsFailed++; $display("[TB] FAIL idle_track: got (%0d,%0d) expected (6,5)", BALL_X, BALL_Y); end
    @(negedge CLK) PUSH = 4'b0011;
    @(negedge CLK) PUSH = 4'b0000;
    repeat (2) @(negedge CLK);
    testsRun++;
    if (PAD1_X !== 3'd4) begin testsFailed++; $display("[TB] FAIL left_priority: got %0d expected 4", PAD1_X); end
    pulseBtn(1, 5);
    testsRun++;
    if (PAD1_X !== 3'd0) begin testsFailed++; $display("[TB] FAIL pad1_left_clamp: got %0d expected 0", PAD1_X); end
    pulseBtn(3, 6);
    testsRun++;
    if (PAD2_X !== 3'd0) begin testsFailed++; $display("[TB] FAIL pad2_left_clamp: got %0d expected 0", PAD2_X); end
    testsRun++;
    if ({BALL_X, BALL_Y, STATE} !== {3'd1, 3'd5, 2'd0}) begin testsFailed++; $display("[TB] FAIL idle_park: got (%0d,%0d) state %0d expected (1,5) state 0", BALL_X, BALL_Y, STATE); end
  endtask

  task automatic test_serve_reflect;
    logic [5:0] seq [4];
    logic [5:0] prev, cur;
    bit ok;
    seq = '{{3'd1, 3'd4}, {3'd1, 3'd3}, {3'd1, 3'd2}, {3'd1, 3'd3}};
    @(negedge CLK) SERVE = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL serve_to_play: got state %0d expected 1", STATE); end
    prev = {BALL_X, BALL_Y};
    testsRun++;
    if (prev !== {3'd1, 3'd5}) begin testsFailed++; $display("[TB] FAIL serve_start: got (%0d,%0d) expected (1,5)", prev[5:3], prev[2:0]); end
    for (int i = 0; i < 4; i++) begin
      waitBallChange(prev, cur, ok);
      testsRun++;
      if (!ok || cur !== seq[i]) begin testsFailed++; $display("[TB] FAIL rise_step%0d: got (%0d,%0d) timeout=%0d expected (%0d,%0d)", i, cur[5:3], cur[2:0], !ok, seq[i][5:3], seq[i][2:0]); end
      prev = cur;
    end
  endtask

  task automatic test_point_p1;
    bit ok;
    pulseBtn(2, 5);
    testsRun++;
    if (PAD2_X !== 3'd5) begin testsFailed++; $display("[TB] FAIL pad2_move: got %0d expected 5", PAD2_X); end
    waitState(2'd2, 200, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL p1_point_wait: got state %0d expected 2", STATE); end
    testsRun++;
    if ({SCORE1, SCORE2} !== {4'd1, 4'd0}) begin testsFailed++; $display("[TB] FAIL p1_score: got %0d/%0d expected 1/0", SCORE1, SCORE2); end
    testsRun++;
    if (POINT_PULSE !== 1'b1) begin testsFailed++; $display("[TB] FAIL pulse_high: got %0d expected 1", POINT_PULSE); end
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd1, 3'd0}) begin testsFailed++; $display("[TB] FAIL point_ball: got (%0d,%0d) expected (1,0)", BALL_X, BALL_Y); end
    @(negedge CLK);
    testsRun++;
    if (POINT_PULSE !== 1'b0 || STATE !== 2'd2) begin testsFailed++; $display("[TB] FAIL pulse_one_cycle: got pulse %0d state %0d expected 0 2", POINT_PULSE, STATE); end
    waitState(2'd0, 20, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL point_to_idle: got state %0d expected 0", STATE); end
    repeat (2) @(negedge CLK);
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd6, 3'd2}) begin testsFailed++; $display("[TB] FAIL p2_serves: got (%0d,%0d) expected (6,2)", BALL_X, BALL_Y); end
    repeat (8) @(negedge CLK);
    testsRun++;
    if (STATE !== 2'd0) begin testsFailed++; $display("[TB] FAIL serve_level_no_retrigger: got state %0d expected 0", STATE); end
    SERVE = 1'b0;
  endtask

  task automatic test_hit_edges;
    logic [5:0] seq [11];
    logic [5:0] prev, cur;
    bit ok;
    seq = '{{3'd6, 3'd3}, {3'd6, 3'd4}, {3'd6, 3'd5}, {3'd7, 3'd4}, {3'd6, 3'd3}, {3'd5, 3'd2},
            {3'd4, 3'd3}, {3'd3, 3'd4}, {3'd2, 3'd5}, {3'd1, 3'd6}, {3'd0, 3'd7}};
    pulseBtn(0, 4);
    testsRun++;
    if (PAD1_X !== 3'd4) begin testsFailed++; $display("[TB] FAIL pad1_to4: got %0d expected 4", PAD1_X); end
    @(negedge CLK) SERVE = 1'b1;
    waitState(2'd1, 10, ok);
    SERVE = 1'b0;
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL p2_serve: got state %0d expected 1", STATE); end
    prev = {BALL_X, BALL_Y};
    for (int i = 0; i < 11; i++) begin
      waitBallChange(prev, cur, ok);
      testsRun++;
      if (!ok || cur !== seq[i]) begin testsFailed++; $display("[TB] FAIL edge_step%0d: got (%0d,%0d) timeout=%0d expected (%0d,%0d)", i, cur[5:3], cur[2:0], !ok, seq[i][5:3], seq[i][2:0]); end
      prev = cur;
    end
    waitState(2'd2, 40, ok);
    testsRun++;
    if (!ok || {SCORE1, SCORE2} !== {4'd1, 4'd1}) begin testsFailed++; $display("[TB] FAIL p2_point: got %0d/%0d timeout=%0d expected 1/1", SCORE1, SCORE2, !ok); end
    waitState(2'd0, 20, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL p2_point_idle: got state %0d expected 0", STATE); end
  endtask

  task automatic test_game_over;
    bit ok;
    repeat (2) @(negedge CLK);
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd5, 3'd5}) begin testsFailed++; $display("[TB] FAIL p1_serves: got (%0d,%0d) expected (5,5)", BALL_X, BALL_Y); end
    pulseBtn(3, 5);
    @(negedge CLK) SERVE = 1'b1;
    waitState(2'd1, 10, ok);
    SERVE = 1'b0;
    waitState(2'd3, 200, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL over_wait: got state %0d expected 3", STATE); end
    testsRun++;
    if ({SCORE1, SCORE2} !== {4'd2, 4'd1}) begin testsFailed++; $display("[TB] FAIL final_score: got %0d/%0d expected 2/1", SCORE1, SCORE2); end
    testsRun++;
    if ({BALL_X, BALL_Y} !== {3'd5, 3'd0}) begin testsFailed++; $display("[TB] FAIL over_ball: got (%0d,%0d) expected (5,0)", BALL_X, BALL_Y); end
    pulseBtn(1, 1);
    testsRun++;
    if (PAD1_X !== 3'd3 || {BALL_X, BALL_Y} !== {3'd5, 3'd0}) begin testsFailed++; $display("[TB] FAIL over_paddle: got pad1 %0d ball (%0d,%0d) expected 3 (5,0)", PAD1_X, BALL_X, BALL_Y); end
    @(negedge CLK) SERVE = 1'b1;
    waitState(2'd0, 10, ok);
    SERVE = 1'b0;
    testsRun++;
    if (!ok || {SCORE1, SCORE2} !== 8'h00) begin testsFailed++; $display("[TB] FAIL restart: got %0d/%0d timeout=%0d expected 0/0", SCORE1, SCORE2, !ok); end
  endtask

  task automatic test_reset_mid_play;
    bit ok;
    repeat (2) @(negedge CLK);
    SERVE = 1'b1;
    waitState(2'd1, 10, ok);
    SERVE = 1'b0;
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL replay: got state %0d expected 1", STATE); end
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    testsRun++;
    if ({PAD1_X, PAD2_X} !== {3'd0, 3'd5}) begin testsFailed++; $display("[TB] FAIL async_pads: got %0d/%0d expected 0/5", PAD1_X, PAD2_X); end
    testsRun++;
    if ({BALL_X, BALL_Y, STATE} !== {3'd1, 3'd5, 2'd0}) begin testsFailed++; $display("[TB] FAIL async_ball: got (%0d,%0d) state %0d expected (1,5) 0", BALL_X, BALL_Y, STATE); end
    @(negedge CLK) RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_paddles();
    test_serve_reflect();
    test_point_p1();
    test_hit_edges();
    test_game_over();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
